// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : EXE/MEM + MEM/WB pipeline registers with a req/ack data port
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int WORD_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] ALURes,
  input  logic [WORD_LEN-1:0] PCplus4,
  input  logic [WORD_LEN-1:0] rd2,
  input  logic [WORD_LEN-1:0] Instruction,
  input  logic [1:0]          WBsel,
  input  logic                Reg_W_En,
  input  logic                Mem_W_En,
  input  logic                Mem_R_En,
  output logic                stall,
  output logic [WORD_LEN-1:0] ALURes_EXE2MEM,
  output logic [WORD_LEN-1:0] Mem_Data_MEM2WB,
  output logic [WORD_LEN-1:0] Instruction_WB,
  output logic                Reg_W_En_WB,
  output logic                mem_fault,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  input  logic                dmem_ack
);

  localparam int                CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_LEN-1:0] alures;
    logic [WORD_LEN-1:0] pc4;
    logic [WORD_LEN-1:0] rd2;
    logic [WORD_LEN-1:0] instr;
    logic [1:0]          wbsel;
    logic                reg_w;
    logic                mem_w;
    logic                mem_r;
  } exe_t;

  typedef struct packed {
    logic [WORD_LEN-1:0] data;
    logic [WORD_LEN-1:0] instr;
    logic                reg_w;
    logic                fault;
  } wb_t;

  exe_t             a_d, a_q;
  wb_t              b_d, b_q;
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [2:0]          funct3;
  logic                memop;
  logic                misaligned;
  logic                last_wait;
  logic                fault;
  logic [3:0]          be_raw;
  logic [WORD_LEN-1:0] wdata_raw;
  logic [WORD_LEN-1:0] byte_shift;
  logic [15:0]         half_sel;
  logic [WORD_LEN-1:0] load_data;

  assign funct3     = a_q.instr[14:12];
  assign memop      = a_q.mem_r | a_q.mem_w;
  assign misaligned = memop & (((funct3[1:0] == 2'b01) & a_q.alures[0]) |
                               ((funct3[1:0] == 2'b10) & (a_q.alures[1:0] != 2'b00)));
  assign last_wait  = (state_q == ST_ACCESS) & (cnt_q == CNT_MAX);

  // Request is live straight from EXE/MEM so a same-cycle ack costs no stall.
  assign dmem_req = memop & ~misaligned;
  assign stall    = dmem_req & ~dmem_ack & ~last_wait;
  assign fault    = misaligned | (last_wait & ~dmem_ack);

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = '0;
    if (a_q.mem_w) begin
      case (funct3[1:0])
        2'b00: begin
          be_raw    = 4'b0001 << a_q.alures[1:0];
          wdata_raw = {4{a_q.rd2[7:0]}};
        end
        2'b01: begin
          be_raw    = a_q.alures[1] ? 4'b1100 : 4'b0011;
          wdata_raw = {2{a_q.rd2[15:0]}};
        end
        default: begin
          be_raw    = 4'b1111;
          wdata_raw = a_q.rd2;
        end
      endcase
    end
  end

  assign dmem_we    = dmem_req & a_q.mem_w;
  assign dmem_be    = dmem_req ? be_raw : 4'b0000;
  assign dmem_wdata = dmem_req ? wdata_raw : '0;
  assign dmem_addr  = dmem_req ? {a_q.alures[WORD_LEN-1:2], 2'b00} : '0;

  assign byte_shift = dmem_rdata >> {a_q.alures[1:0], 3'b000};
  assign half_sel   = a_q.alures[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_shift[7:0]};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    a_d = a_q;
    if (!stall) begin
      if (flush) begin
        a_d = '0;
      end else begin
        a_d.alures = ALURes;
        a_d.pc4    = PCplus4;
        a_d.rd2    = rd2;
        a_d.instr  = Instruction;
        a_d.wbsel  = WBsel;
        a_d.reg_w  = Reg_W_En;
        a_d.mem_w  = Mem_W_En;
        a_d.mem_r  = Mem_R_En;
      end
    end
  end

  // MEM/WB takes a bubble while the access is still pending.
  always_comb begin
    b_d = '0;
    if (!stall) begin
      case (a_q.wbsel)
        2'b01:   b_d.data = load_data;
        2'b10:   b_d.data = a_q.pc4;
        default: b_d.data = a_q.alures;
      endcase
      b_d.instr = a_q.instr;
      b_d.reg_w = a_q.reg_w & ~fault;
      b_d.fault = fault;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (dmem_ack || (cnt_q == CNT_MAX)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALURes_EXE2MEM  = a_q.alures;
  assign Mem_Data_MEM2WB = b_q.data;
  assign Instruction_WB  = b_q.instr;
  assign Reg_W_En_WB     = b_q.reg_w;
  assign mem_fault       = b_q.fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] ALURes, PCplus4, rd2, Instruction;
  logic [1:0]  WBsel;
  logic        Reg_W_En, Mem_W_En, Mem_R_En;
  logic        stall;
  logic [31:0] ALURes_EXE2MEM, Mem_Data_MEM2WB, Instruction_WB;
  logic        Reg_W_En_WB, mem_fault;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  int total = 0;
  int bad   = 0;

  mem_stage #(.WORD_LEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ALURes(ALURes), .PCplus4(PCplus4), .rd2(rd2), .Instruction(Instruction),
    .WBsel(WBsel), .Reg_W_En(Reg_W_En), .Mem_W_En(Mem_W_En), .Mem_R_En(Mem_R_En),
    .stall(stall), .ALURes_EXE2MEM(ALURes_EXE2MEM), .Mem_Data_MEM2WB(Mem_Data_MEM2WB),
    .Instruction_WB(Instruction_WB), .Reg_W_En_WB(Reg_W_En_WB), .mem_fault(mem_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exe(input logic [31:0] alu, pc4, d2, ins,
                           input logic [1:0] wb, input logic rw, mw, mr);
    ALURes = alu; PCplus4 = pc4; rd2 = d2; Instruction = ins;
    WBsel = wb; Reg_W_En = rw; Mem_W_En = mw; Mem_R_En = mr;
  endtask

  task automatic drive_bubble;
    drive_exe(32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    drive_exe(32'h0000_0104, 32'h44, 32'h55, 32'h0000_2283, 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle;
    next_cycle;
    @(negedge clk);
    total++;
    if ({ALURes_EXE2MEM, Mem_Data_MEM2WB, Instruction_WB} !== 96'h0) begin
      bad++; $display("FAIL reset_data: got %h %h %h want 0 0 0", ALURes_EXE2MEM, Mem_Data_MEM2WB, Instruction_WB);
    end
    total++;
    if ({stall, dmem_req, Reg_W_En_WB, mem_fault, dmem_we, dmem_be} !== 9'h0) begin
      bad++; $display("FAIL reset_ctrl: got stall=%b req=%b rw=%b flt=%b we=%b be=%b want all 0",
                      stall, dmem_req, Reg_W_En_WB, mem_fault, dmem_we, dmem_be);
    end
    total++;
    if ({dmem_addr, dmem_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_dmem: got addr=%h wdata=%h want 0 0", dmem_addr, dmem_wdata);
    end
    rst_n = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_bubble;
    next_cycle;
    @(negedge clk);
    total++;
    if ({stall, dmem_req, Reg_W_En_WB, mem_fault, ALURes_EXE2MEM, Mem_Data_MEM2WB} !== 68'h0) begin
      bad++; $display("FAIL reset_release: got stall=%b req=%b rw=%b flt=%b alu=%h data=%h want all 0",
                      stall, dmem_req, Reg_W_En_WB, mem_fault, ALURes_EXE2MEM, Mem_Data_MEM2WB);
    end
  endtask

  task automatic test_alu_back_to_back;
    drive_exe(32'h0000_1234, 32'h40, 32'h0, 32'h0000_0293, 2'b00, 1'b1, 1'b0, 1'b0);
    next_cycle;
    drive_exe(32'h0000_0055, 32'h0000_2000, 32'h0, 32'h0000_00EF, 2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (ALURes_EXE2MEM !== 32'h0000_1234) begin
      bad++; $display("FAIL alu_exe2mem: got %h want 00001234", ALURes_EXE2MEM);
    end
    total++;
    if ({dmem_req, stall} !== 2'b00) begin
      bad++; $display("FAIL alu_noreq: got req=%b stall=%b want 0 0", dmem_req, stall);
    end
    next_cycle;
    drive_exe(32'h0000_0777, 32'h0, 32'h0, 32'h0000_0293, 2'b11, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({Mem_Data_MEM2WB, Reg_W_En_WB, Instruction_WB} !== {32'h0000_1234, 1'b1, 32'h0000_0293}) begin
      bad++; $display("FAIL alu_wb: got data=%h rw=%b ins=%h want 00001234 1 00000293",
                      Mem_Data_MEM2WB, Reg_W_En_WB, Instruction_WB);
    end
    total++;
    if (ALURes_EXE2MEM !== 32'h0000_0055) begin
      bad++; $display("FAIL b2b_exe2mem: got %h want 00000055", ALURes_EXE2MEM);
    end
    next_cycle;
    drive_bubble;
    @(negedge clk);
    total++;
    if (Mem_Data_MEM2WB !== 32'h0000_2000) begin
      bad++; $display("FAIL wbsel_pc4: got %h want 00002000", Mem_Data_MEM2WB);
    end
    next_cycle;
    @(negedge clk);
    total++;
    if (Mem_Data_MEM2WB !== 32'h0000_0777) begin
      bad++; $display("FAIL wbsel_rsvd: got %h want 00000777", Mem_Data_MEM2WB);
    end
    next_cycle;
    @(negedge clk);
    total++;
    if (Reg_W_En_WB !== 1'b0) begin
      bad++; $display("FAIL bubble_wb: got rw=%b want 0", Reg_W_En_WB);
    end
  endtask

  task automatic test_load(input string nm, input logic [31:0] addr, ins, rdata,
                           exp, input int ack_on, input bit do_flush);
    drive_exe(addr, 32'h0, 32'h0, ins, 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle;
    drive_bubble;
    dmem_rdata = rdata;
    for (int k = 1; k <= ack_on; k++) begin
      dmem_ack = (k == ack_on);
      if (do_flush && k == 2) begin
        flush = 1'b1;
        drive_exe(32'hBAD0_0000, 32'h1, 32'h2, 32'h0000_0293, 2'b00, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      total++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1111, addr[31:2], 2'b00}) begin
        bad++; $display("FAIL %s_port c%0d: got req=%b we=%b be=%b addr=%h want 1 0 1111 %h",
                        nm, k, dmem_req, dmem_we, dmem_be, dmem_addr, {addr[31:2], 2'b00});
      end
      total++;
      if (stall !== (k < ack_on)) begin
        bad++; $display("FAIL %s_stall c%0d: got %b want %b", nm, k, stall, (k < ack_on));
      end
      total++;
      if (ALURes_EXE2MEM !== addr) begin
        bad++; $display("FAIL %s_hold c%0d: got %h want %h", nm, k, ALURes_EXE2MEM, addr);
      end
      next_cycle;
      flush = 1'b0;
      drive_bubble;
    end
    dmem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({Mem_Data_MEM2WB, Reg_W_En_WB, mem_fault, dmem_req} !== {exp, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL %s_data: got data=%h rw=%b flt=%b req=%b want %h 1 0 0",
                      nm, Mem_Data_MEM2WB, Reg_W_En_WB, mem_fault, dmem_req, exp);
    end
  endtask

  task automatic test_store(input string nm, input logic [31:0] addr, data, ins,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    drive_exe(addr, 32'h0, data, ins, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle;
    drive_bubble;
    dmem_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, stall} !==
        {1'b1, 1'b1, exp_be, exp_wd, addr[31:2], 2'b00, 1'b0}) begin
      bad++; $display("FAIL %s_port: got req=%b we=%b be=%b wd=%h addr=%h stall=%b want 1 1 %b %h %h 0",
                      nm, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, stall,
                      exp_be, exp_wd, {addr[31:2], 2'b00});
    end
    next_cycle;
    dmem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({Reg_W_En_WB, mem_fault, dmem_req, stall} !== 4'b0000) begin
      bad++; $display("FAIL %s_retire: got rw=%b flt=%b req=%b stall=%b want 0 0 0 0",
                      nm, Reg_W_En_WB, mem_fault, dmem_req, stall);
    end
  endtask

  task automatic test_misaligned(input string nm, input logic [31:0] addr, ins);
    drive_exe(addr, 32'h0, 32'h0, ins, 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle;
    drive_bubble;
    @(negedge clk);
    total++;
    if ({dmem_req, stall} !== 2'b00) begin
      bad++; $display("FAIL %s_noreq: got req=%b stall=%b want 0 0", nm, dmem_req, stall);
    end
    next_cycle;
    @(negedge clk);
    total++;
    if ({mem_fault, Reg_W_En_WB, Instruction_WB} !== {1'b1, 1'b0, ins}) begin
      bad++; $display("FAIL %s_fault: got flt=%b rw=%b ins=%h want 1 0 %h",
                      nm, mem_fault, Reg_W_En_WB, Instruction_WB, ins);
    end
    next_cycle;
    @(negedge clk);
    total++;
    if (mem_fault !== 1'b0) begin
      bad++; $display("FAIL %s_pulse: got flt=%b want 0", nm, mem_fault);
    end
  endtask

  task automatic test_timeout(input string nm, input int reset_at);
    int reqs = 0;
    int stalls = 0;
    bit ended = 0;
    drive_exe(32'h0000_0100, 32'h0, 32'h0, 32'h0000_2283, 2'b01, 1'b1, 1'b0, 1'b1);
    next_cycle;
    drive_bubble;
    dmem_ack = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rst_n = (c == reset_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!dmem_req) begin
        ended = 1;
        break;
      end
      reqs++;
      if (stall) stalls++;
      next_cycle;
    end
    rst_n = 1'b1;
    total++;
    if ({ended, reqs, stalls} !== (reset_at == 0 ? {1'b1, 32'd16, 32'd15}
                                                 : {1'b1, reset_at, reset_at})) begin
      bad++; $display("FAIL %s_counts: got ended=%b req=%0d stall=%0d want 1 %0d %0d", nm, ended,
                      reqs, stalls, (reset_at == 0) ? 16 : reset_at, (reset_at == 0) ? 15 : reset_at);
    end
    total++;
    if ({mem_fault, Reg_W_En_WB, stall} !== {(reset_at == 0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL %s_end: got flt=%b rw=%b stall=%b want %b 0 0",
                      nm, mem_fault, Reg_W_En_WB, stall, (reset_at == 0));
    end
    next_cycle;
    @(negedge clk);
    total++;
    if ({mem_fault, dmem_req, stall} !== 3'b000) begin
      bad++; $display("FAIL %s_after: got flt=%b req=%b stall=%b want 0 0 0",
                      nm, mem_fault, dmem_req, stall);
    end
  endtask

  initial begin
    flush = 1'b0; rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_bubble;
    test_reset;
    test_alu_back_to_back;
    test_load("lb",  32'h0000_0103, 32'h0000_0283, 32'h80FF_0000, 32'hFFFF_FF80, 3, 1'b0);
    test_load("lbu", 32'h0000_0103, 32'h0000_4283, 32'h80FF_0000, 32'h0000_0080, 3, 1'b1);
    test_load("lh",  32'h0000_0202, 32'h0000_1283, 32'h8001_7F00, 32'hFFFF_8001, 1, 1'b0);
    test_load("lhu", 32'h0000_0202, 32'h0000_5283, 32'h8001_7F00, 32'h0000_8001, 2, 1'b0);
    test_load("lw",  32'h0000_0300, 32'h0000_2283, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0);
    test_store("sh", 32'h0000_0102, 32'h0000_ABCD, 32'h0000_1023, 4'b1100, 32'hABCD_ABCD);
    test_store("sb", 32'h0000_0101, 32'h1234_565A, 32'h0000_0023, 4'b0010, 32'h5A5A_5A5A);
    test_store("sw", 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_2023, 4'b1111, 32'hCAFE_F00D);
    test_misaligned("lw_mis", 32'h0000_0101, 32'h0000_2283);
    test_misaligned("lh_mis", 32'h0000_0103, 32'h0000_1283);
    test_timeout("tmo", 0);
    test_timeout("tmo_rst", 3);
    test_timeout("tmo_again", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
